reset_pulse_gen: RTL

//  Initiator side of the board reset chain: drives the async reset input (ASYNC_RSTb) of

---
 rtl/reset_pulse_gen_if.sv | 52 +++++
 rtl/reset_pulse_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reset_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// reset_pulse_gen_if
//
// Purpose:
//   Bundles the request/acknowledge and status signals of the board reset
//   initiator (reset_pulse_gen). The clock and own reset stay plain ports on
//   the module.
//
// Signals:
//   REQ          soft reset request, sampled on every CK edge
//   ACK_RSTb     released SYNC_RSTb of the downstream synchroniser, async to CK
//   RST_OUTb     active-low reset driven into downstream ASYNC_RSTb
//   BUSY         high while a sequence is in progress
//   DONE         one-cycle completion strobe
//   TIMEOUT_ERR  sticky acknowledge-timeout flag
//   REQ_COUNT    number of accepted soft requests, wraps at 256
//
// Modports:
//   master  the reset initiator (drives RST_OUTb and status)
//   slave   the environment (drives REQ and ACK_RSTb, observes status)
// -----------------------------------------------------------------------------
interface reset_pulse_gen_if;

    logic       REQ;
    logic       ACK_RSTb;
    logic       RST_OUTb;
    logic       BUSY;
    logic       DONE;
    logic       TIMEOUT_ERR;
    logic [7:0] REQ_COUNT;

    modport master (
        input  REQ,
        input  ACK_RSTb,
        output RST_OUTb,
        output BUSY,
        output DONE,
        output TIMEOUT_ERR,
        output REQ_COUNT
    );

    modport slave (
        output REQ,
        output ACK_RSTb,
        input  RST_OUTb,
        input  BUSY,
        input  DONE,
        input  TIMEOUT_ERR,
        input  REQ_COUNT
    );

endinterface

// File: rtl/reset_pulse_gen.sv
// -----------------------------------------------------------------------------
// reset_pulse_gen
//
// Purpose:
//   Initiator side of the board reset chain. Drives the asynchronous reset
//   input of downstream reset synchronisers and uses their released
//   synchronous reset as an acknowledge. After its own reset it issues a
//   power-on pulse; afterwards it issues one fixed-width pulse per accepted
//   soft request. Requests arriving while a sequence runs are merged into a
//   single pending request.
//
// Parameters:
//   PULSE_LEN  cycles RST_OUTb is held low per pulse (>= 2)
//   CNT_W      width of the pulse and timeout counters
//   TIMEOUT    max cycles spent waiting for the acknowledge (timeout build only)
//
// Ports:
//   CK    clock (control/register domain)
//   RSTb  synchronous active-low reset
//   bus   reset_pulse_gen_if.master:
//           REQ (in), ACK_RSTb (in, async), RST_OUTb (out, registered),
//           BUSY (out), DONE (out), TIMEOUT_ERR (out), REQ_COUNT[7:0] (out)
//
// Configuration:
//   RESET_TIMEOUT_EN  when defined, a timeout counter runs while waiting for
//                     the acknowledge; on expiry TIMEOUT_ERR is set and the
//                     sequence completes anyway. When undefined, the wait is
//                     unbounded and TIMEOUT_ERR is tied low.
// -----------------------------------------------------------------------------
module reset_pulse_gen #(
    parameter int unsigned PULSE_LEN = 16,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic              CK,
    input  logic              RSTb,
    reset_pulse_gen_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StWaitAck,
        StFin
    } state_t;

    localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_LEN - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rst_outb_q;
    logic             busy_q;
    logic             done_q;
    logic             pending_q;
    logic             seen_low_q;
    logic [7:0]       req_count_q;

    // Two-flop synchroniser for the acknowledge; nothing else touches the raw input.
    logic             ack_meta_q;
    logic             ack_s_q;

`ifdef RESET_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] tcnt_q;
    logic             timeout_err_q;
`endif

    always_ff @(posedge CK) begin
        if (!RSTb) begin
            // Reset lands in StAssert so the power-on pulse starts with the
            // first edge that sees RSTb high.
            state_q     <= StAssert;
            cnt_q       <= '0;
            rst_outb_q  <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pending_q   <= 1'b0;
            seen_low_q  <= 1'b0;
            req_count_q <= 8'd0;
            ack_meta_q  <= 1'b1;
            ack_s_q     <= 1'b1;
`ifdef RESET_TIMEOUT_EN
            tcnt_q        <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            ack_meta_q <= bus.ACK_RSTb;
            ack_s_q    <= ack_meta_q;
            done_q     <= 1'b0;

            case (state_q)
                StIdle: begin
                    rst_outb_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (bus.REQ || pending_q) begin
                        state_q     <= StAssert;
                        pending_q   <= 1'b0;
                        req_count_q <= req_count_q + 8'd1;
                        seen_low_q  <= 1'b0;
                        cnt_q       <= '0;
                        rst_outb_q  <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef RESET_TIMEOUT_EN
                        timeout_err_q <= 1'b0;
`endif
                    end
                end

                StAssert: begin
                    if (bus.REQ) begin
                        pending_q <= 1'b1;
                    end
                    if (!ack_s_q) begin
                        seen_low_q <= 1'b1;
                    end
                    if (cnt_q == PulseLast) begin
                        state_q    <= StWaitAck;
                        cnt_q      <= '0;
                        rst_outb_q <= 1'b1;
`ifdef RESET_TIMEOUT_EN
                        tcnt_q     <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StWaitAck: begin
                    if (bus.REQ) begin
                        pending_q <= 1'b1;
                    end
                    if (!ack_s_q) begin
                        seen_low_q <= 1'b1;
                    end
                    // Only a release that follows an observed low counts, so a
                    // stale high acknowledge cannot end the sequence early.
                    if (seen_low_q && ack_s_q) begin
                        state_q <= StFin;
                        done_q  <= 1'b1;
                    end
`ifdef RESET_TIMEOUT_EN
                    else if (tcnt_q == TimeoutLast) begin
                        state_q       <= StFin;
                        done_q        <= 1'b1;
                        timeout_err_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
`endif
                end

                StFin: begin
                    // A request here is held as pending; IDLE picks it up after
                    // one cycle with RST_OUTb high.
                    if (bus.REQ) begin
                        pending_q <= 1'b1;
                    end
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q    <= StIdle;
                    rst_outb_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RST_OUTb  = rst_outb_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.REQ_COUNT = req_count_q;

`ifdef RESET_TIMEOUT_EN
    assign bus.TIMEOUT_ERR = timeout_err_q;
`else
    assign bus.TIMEOUT_ERR = 1'b0;
`endif

endmodule
